adain_stat_ctrl: RTL and testbench

- Control sequencer for one AdaIN channel. Drives the 3-bit `state` code, `lead_zero_N` and `lead_zero_var` into the shift-amount generator that sits directly downstream.
- Runs three streaming passes per channel: mean, variance and normalize. An inverse-sqrt step runs between the variance and normalize passes.
- Counts stream beats, gates the MAC, and captures the variance leading-zero count.

---
 rtl/adain_pkg.sv | 18 +
 rtl/lzc_var.sv | 23 ++
 rtl/adain_stat_ctrl.sv | 173 +++++++++++++++++
 tb/tb_adain_stat_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/adain_pkg.sv
// Shared definitions for the AdaIN statistics controller: phase codes and derived widths.
package adain_pkg;

    localparam int N_MAX_DEF        = 256;
    localparam int WIDTH_MAC_IN_DEF = 48;
    localparam int WIDTH_N          = $clog2(N_MAX_DEF + 1);
    localparam int INVSQRT_SHIFT_IN = WIDTH_MAC_IN_DEF - 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_MEAN    = 3'b001,
        ST_VAR     = 3'b010,
        ST_INVSQRT = 3'b011,
        ST_NORM    = 3'b100,
        ST_DONE    = 3'b101
    } state_e;

endpackage

// File: rtl/lzc_var.sv
// Combinational leading-zero counter; count is 0 and zero_o is set for an all-zero word.
module lzc_var #(
    parameter int W  = 48,
    parameter int CW = $clog2(W)
) (
    input  logic [W-1:0]  data_i,
    output logic [CW-1:0] count_o,
    output logic          zero_o
);

    // Ascending scan: the highest set bit is the last one to overwrite the count.
    always_comb begin
        count_o = '0;
        zero_o  = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) begin
                count_o = CW'(W - 1 - i);
                zero_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adain_stat_ctrl.sv
// AdaIN per-channel sequencer: mean, variance and normalize passes with an inverse-sqrt step,
// beat counting, MAC gating and capture of the variance leading-zero count.
module adain_stat_ctrl
    import adain_pkg::*;
#(
    parameter int N_MAX        = N_MAX_DEF,
    parameter int WIDTH_MAC_IN = WIDTH_MAC_IN_DEF,
    parameter int SETTLE_CYC   = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [$clog2(N_MAX+1)-1:0]            n_elems,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic                                  mac_clr,
    output logic                                  mac_en,
    input  logic [WIDTH_MAC_IN-1:0]               var_in,
    input  logic                                  var_valid,
    output logic                                  invsqrt_start,
    input  logic                                  invsqrt_done,
    output logic [2:0]                            state,
    output logic [$clog2($clog2(N_MAX+1))-1:0]    lead_zero_N,
    output logic [$clog2(WIDTH_MAC_IN)-1:0]       lead_zero_var,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    localparam int WN    = $clog2(N_MAX + 1);
    localparam int LZN_W = $clog2(WN);
    localparam int LZV_W = $clog2(WIDTH_MAC_IN);
    localparam int SW    = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    state_e             state_q;
    logic [SW-1:0]      settle_q;
    logic [WN-1:0]      cnt_q;
    logic [WN-1:0]      n_q;
    logic               var_wait_q;
    logic [LZN_W-1:0]   lz_n_q;
    logic [LZV_W-1:0]   lz_var_q;
    logic               err_q;
    logic               done_q;
    logic               mac_clr_q;
    logic               inv_start_q;
    logic               busy_q;

    logic               in_pass;
    logic               beat;
    logic               last_beat;
    logic               n_ok;
    logic [LZN_W-1:0]   msb_idx;
    logic [LZV_W-1:0]   lz_cnt;
    logic               lz_zero;
    logic [LZV_W-1:0]   lz_var_d;

    lzc_var #(
        .W  (WIDTH_MAC_IN),
        .CW (LZV_W)
    ) u_lzc (
        .data_i  (var_in),
        .count_o (lz_cnt),
        .zero_o  (lz_zero)
    );

    // A zero variance saturates so the downstream left shift becomes zero.
    assign lz_var_d = lz_zero ? LZV_W'(WIDTH_MAC_IN - 2) : lz_cnt;

    assign in_pass   = (state_q == ST_MEAN) || (state_q == ST_VAR) || (state_q == ST_NORM);
    assign in_ready  = in_pass && (settle_q == '0) && !var_wait_q;
    assign beat      = in_valid && in_ready;
    assign mac_en    = beat;
    assign last_beat = beat && (cnt_q == n_q - WN'(1));
    assign n_ok      = (n_elems != '0) && ((n_elems & (n_elems - WN'(1))) == '0);

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < WN; i++) begin
            if (n_elems[i]) msb_idx = LZN_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            var_wait_q  <= 1'b0;
            lz_n_q      <= '0;
            lz_var_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            mac_clr_q   <= 1'b0;
            inv_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mac_clr_q   <= 1'b0;
            inv_start_q <= 1'b0;
            done_q      <= 1'b0;
            if (settle_q != '0) settle_q <= settle_q - SW'(1);
            if (beat) cnt_q <= last_beat ? '0 : cnt_q + WN'(1);

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        n_q <= n_elems;
                        if (!n_ok) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            err_q     <= 1'b0;
                            lz_n_q    <= msb_idx;
                            mac_clr_q <= 1'b1;
                            cnt_q     <= '0;
                            settle_q  <= SW'(SETTLE_CYC);
                            busy_q    <= 1'b1;
                            state_q   <= ST_MEAN;
                        end
                    end
                end
                ST_MEAN: begin
                    if (last_beat) begin
                        mac_clr_q <= 1'b1;
                        settle_q  <= SW'(SETTLE_CYC);
                        state_q   <= ST_VAR;
                    end
                end
                ST_VAR: begin
                    // var_valid counts only once the last beat is in (or arrives with it).
                    if ((var_wait_q || last_beat) && var_valid) begin
                        lz_var_q    <= lz_var_d;
                        var_wait_q  <= 1'b0;
                        inv_start_q <= 1'b1;
                        state_q     <= ST_INVSQRT;
                    end else if (last_beat) begin
                        var_wait_q <= 1'b1;
                    end
                end
                ST_INVSQRT: begin
                    if (invsqrt_done) begin
                        settle_q <= SW'(SETTLE_CYC);
                        state_q  <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (last_beat) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state         = state_q;
    assign lead_zero_N   = lz_n_q;
    assign lead_zero_var = lz_var_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign mac_clr       = mac_clr_q;
    assign invsqrt_start = inv_start_q;

endmodule

// File: tb/tb_adain_stat_ctrl.sv
// Directed bench for adain_stat_ctrl: per-channel runs with hand-computed expectations.
module tb_adain_stat_ctrl;

    localparam int BUDGET = 6000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  n_elems;
    logic        in_valid;
    logic        in_ready;
    logic        mac_clr;
    logic        mac_en;
    logic [47:0] var_in;
    logic        var_valid;
    logic        invsqrt_start;
    logic        invsqrt_done;
    logic [2:0]  state;
    logic [3:0]  lead_zero_N;
    logic [5:0]  lead_zero_var;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    adain_stat_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .n_elems       (n_elems),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mac_clr       (mac_clr),
        .mac_en        (mac_en),
        .var_in        (var_in),
        .var_valid     (var_valid),
        .invsqrt_start (invsqrt_start),
        .invsqrt_done  (invsqrt_done),
        .state         (state),
        .lead_zero_N   (lead_zero_N),
        .lead_zero_var (lead_zero_var),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},  64'(state), 64'(0));
        check({tag, "_busy"},   64'(busy), 64'(0));
        check({tag, "_done"},   64'(done), 64'(0));
        check({tag, "_err"},    64'(err), 64'(0));
        check({tag, "_macclr"}, 64'(mac_clr), 64'(0));
        check({tag, "_invst"},  64'(invsqrt_start), 64'(0));
        check({tag, "_inrdy"},  64'(in_ready), 64'(0));
        check({tag, "_macen"},  64'(mac_en), 64'(0));
        check({tag, "_lzn"},    64'(lead_zero_N), 64'(0));
        check({tag, "_lzv"},    64'(lead_zero_var), 64'(0));
    endtask

    // One channel. Cycle 0 is the first MEAN cycle; with in_valid held high the done
    // pulse lands in cycle 3n+4+vdelay+idelay (settle+n per pass, one INVSQRT entry cycle).
    task automatic run_channel(input string tag, input int n, input logic [47:0] vin,
                               input int vdelay, input int idelay, input bit stall,
                               input bit inject, input int abort_at,
                               input int exp_lzn, input int exp_lzv);
        int cyc = 0;
        int var_last = -1;
        int inv_cyc = -1;
        int done_cnt = 0;
        int done_cyc = -1;
        int clr_cnt = 0;
        int inv_cnt = 0;
        int bts[8];
        logic [17:0] seq = '0;
        logic [2:0]  prev = 3'd0;
        bit aborted = 1'b0;
        bit inj_s = 1'b0;
        bit inj_d = 1'b0;
        for (int k = 0; k < 8; k++) bts[k] = 0;

        @(negedge clk);
        start   = 1'b1;
        n_elems = 9'(n);
        var_in  = vin;
        while (cyc < BUDGET) begin
            @(negedge clk);
            start        = 1'b0;
            var_valid    = 1'b0;
            invsqrt_done = 1'b0;
            if (state != prev) begin
                seq  = {seq[14:0], state};
                prev = state;
            end
            if (cyc == 0) begin
                check({tag, "_c0_state"}, 64'(state), 64'(1));
                check({tag, "_c0_macclr"}, 64'(mac_clr), 64'(1));
                check({tag, "_c0_inrdy"}, 64'(in_ready), 64'(0));
                check({tag, "_c0_busy"}, 64'(busy), 64'(1));
                check({tag, "_c0_err"}, 64'(err), 64'(0));
                check({tag, "_lzn"}, 64'(lead_zero_N), 64'(exp_lzn));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mac_clr) clr_cnt++;
            if (invsqrt_start) begin
                inv_cnt++;
                inv_cyc = cyc;
            end
            if (state == 3'd0) break;

            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (vdelay > 0 && var_last >= 0 && cyc == var_last + vdelay) var_valid = 1'b1;
            if (inv_cyc >= 0 && cyc == inv_cyc + idelay) invsqrt_done = 1'b1;
            if (inject && state == 3'd2 && !inj_s) begin
                start   = 1'b1;
                n_elems = 9'd12;
                inj_s   = 1'b1;
            end
            if (inject && state == 3'd4 && !inj_d) begin
                invsqrt_done = 1'b1;
                inj_d        = 1'b1;
            end
            #1;
            if (mac_en) begin
                bts[state]++;
                if (state == 3'd2 && bts[2] == n) begin
                    var_last = cyc;
                    if (vdelay == 0) var_valid = 1'b1;
                end
            end
            if (abort_at >= 0 && state == 3'd4 && bts[4] == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero({tag, "_abort"});
                aborted = 1'b1;
                break;
            end
            cyc++;
        end
        in_valid = 1'b0;

        if (aborted) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check({tag, "_abort_nodone"}, 64'(done), 64'(0));
            end
            check({tag, "_abort_state"}, 64'(state), 64'(0));
            rst_n = 1'b1;
        end else begin
            check({tag, "_end_state"}, 64'(state), 64'(0));
            check({tag, "_seq"}, 64'(seq), 64'(18'o123450));
            check({tag, "_beats_mean"}, 64'(bts[1]), 64'(n));
            check({tag, "_beats_var"}, 64'(bts[2]), 64'(n));
            check({tag, "_beats_norm"}, 64'(bts[4]), 64'(n));
            check({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
            check({tag, "_macclr_cnt"}, 64'(clr_cnt), 64'(2));
            check({tag, "_invst_cnt"}, 64'(inv_cnt), 64'(1));
            check({tag, "_lzn_held"}, 64'(lead_zero_N), 64'(exp_lzn));
            check({tag, "_lzv"}, 64'(lead_zero_var), 64'(exp_lzv));
            check({tag, "_err"}, 64'(err), 64'(0));
            check({tag, "_busy"}, 64'(busy), 64'(0));
            if (!stall) check({tag, "_latency"}, 64'(done_cyc), 64'(3 * n + 4 + vdelay + idelay));
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        n_elems      = '0;
        in_valid     = 1'b0;
        var_in       = '0;
        var_valid    = 1'b0;
        invsqrt_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal: bit 16 set in a 48-bit word -> 31 leading zeros.
        run_channel("nominal", 16, 48'h0000_0001_0000, 3, 8, 1'b0, 1'b0, -1, 4, 31);
        run_channel("nominal_b32", 16, 48'h0001_0000_0000, 3, 8, 1'b0, 1'b0, -1, 4, 15);

        // Bad count: err and done pulse, no phase change.
        @(negedge clk);
        start   = 1'b1;
        n_elems = 9'd12;
        @(negedge clk);
        start = 1'b0;
        check("bad_done", 64'(done), 64'(1));
        check("bad_err", 64'(err), 64'(1));
        check("bad_state", 64'(state), 64'(0));
        check("bad_busy", 64'(busy), 64'(0));
        check("bad_macclr", 64'(mac_clr), 64'(0));
        @(negedge clk);
        check("bad_done_drop", 64'(done), 64'(0));
        check("bad_err_sticky", 64'(err), 64'(1));

        // Good start clears err; var_valid coincides with the last VAR beat.
        run_channel("n8_simul", 8, 48'h0001_0000_0000, 0, 0, 1'b0, 1'b0, -1, 3, 15);
        // Zero variance saturates to 46; single-element channel.
        run_channel("n1_zero", 1, 48'h0, 2, 1, 1'b0, 1'b0, -1, 0, 46);
        // Ignored start in VAR and invsqrt_done in NORM.
        run_channel("ignored", 4, 48'h8000_0000_0000, 1, 2, 1'b0, 1'b1, -1, 2, 0);
        // Full-size channel with random in_valid gaps.
        run_channel("stall", 256, 48'h0000_0000_0001, 5, 3, 1'b1, 1'b0, -1, 8, 47);
        // Reset in the middle of NORM, then a clean channel.
        run_channel("abort", 32, 48'h0000_0000_0100, 1, 1, 1'b0, 1'b0, 10, 5, 39);
        @(negedge clk);
        run_channel("after_abort", 2, 48'h0000_0000_00FF, 1, 1, 1'b0, 1'b0, -1, 1, 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
